// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - shared types, widths and LFSR helpers for the card round controller
package card_pkg;

   // Round sequencer states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_DEAL = 3'd1,
      ST_SHOW = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   // Card field widths
   localparam int COLOR_W = 2;
   localparam int NUM_W   = 3;

   // Sum the checker looks for
   localparam int TARGET_SUM = 5;

   // Default LFSR seed and Fibonacci taps (bits 15, 13, 12, 10)
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;

   // One Fibonacci step: shift left, feedback is XOR of the tapped bits
   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], ^(l & LFSR_TAPS)};
   endfunction

   // Fold a 3-bit random field onto the card numbers 1..5
   function automatic logic [NUM_W-1:0] map_num(input logic [NUM_W-1:0] r);
      return (r < 3'd5) ? r + 3'd1 : r - 3'd4;
   endfunction

endpackage

// File: rtl/card_lfsr16.sv
// rtl/card_lfsr16.sv - 16-bit Fibonacci LFSR with seed load and step enable
module card_lfsr16
   import card_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        load,
   input  logic        step,
   output logic [15:0] state
);

   // An all-zero seed would lock the register, so fall back to the default
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

   // Load the seed on request, otherwise advance only when stepped
   always_ff @(posedge clk) begin
      if (load) begin
         state <= SEED_EFF;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/card_round_ctrl.sv
// rtl/card_round_ctrl.sv - deals cards, runs the decaying award count and sequences game rounds
module card_round_ctrl
   import card_pkg::*;
#(
   parameter int          NUM_ROUNDS = 10,
   parameter logic [7:0]  COUNT_INIT = 8'd100,
   parameter int          TICK_DIV   = 1000,
   parameter int          GAP_CYCLES = 50,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               finish,
   output logic [COLOR_W-1:0] c1,
   output logic [COLOR_W-1:0] c2,
   output logic [NUM_W-1:0]   n1,
   output logic [NUM_W-1:0]   n2,
   output logic [7:0]         count,
   output logic               round_active,
   output logic [3:0]         round_idx,
   output logic               timeout,
   output logic               game_over
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
   localparam logic [3:0]    LAST_ROUND = 4'(NUM_ROUNDS - 1);

   state_t          state;
   logic [PW-1:0]   presc;
   logic [GW-1:0]   gap_cnt;
   logic [15:0]     lfsr_q;
   logic [15:0]     lfsr_n;

   // The LFSR moves exactly once per round, in the DEAL cycle
   card_lfsr16 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .load  (rst),
      .step  (state == ST_DEAL),
      .state (lfsr_q)
   );

   // Cards are taken from the value the LFSR is about to hold
   assign lfsr_n = lfsr_next(lfsr_q);

   // Round sequencer: deal, count down, gap, repeat until the last round
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         presc        <= '0;
         gap_cnt      <= '0;
         c1           <= '0;
         c2           <= '0;
         n1           <= '0;
         n2           <= '0;
         count        <= '0;
         round_active <= 1'b0;
         round_idx    <= '0;
         timeout      <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_DEAL;
                  round_idx <= '0;
               end
            end
            ST_DEAL: begin
               c1           <= lfsr_n[1:0];
               n1           <= map_num(lfsr_n[4:2]);
               c2           <= lfsr_n[6:5];
               n2           <= map_num(lfsr_n[9:7]);
               count        <= COUNT_INIT;
               presc        <= '0;
               round_active <= 1'b1;
               state        <= ST_SHOW;
            end
            ST_SHOW: begin
               // A push wins over an expiry landing on the same cycle
               if (finish) begin
                  round_active <= 1'b0;
                  gap_cnt      <= '0;
                  state        <= ST_GAP;
               end else if (presc == PRESC_LAST) begin
                  presc <= '0;
                  if (count != 8'd0) begin
                     count <= count - 8'd1;
                  end else begin
                     timeout      <= 1'b1;
                     round_active <= 1'b0;
                     gap_cnt      <= '0;
                     state        <= ST_GAP;
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (round_idx == LAST_ROUND) begin
                     game_over <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     round_idx <= round_idx + 4'd1;
                     state     <= ST_DEAL;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (start) begin
                  round_idx <= '0;
                  game_over <= 1'b0;
                  state     <= ST_DEAL;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_card_round_ctrl.sv
// tb/tb_card_round_ctrl.sv - self-checking bench for card_round_ctrl
module tb_card_round_ctrl;

   localparam int          NR   = 2;
   localparam int          CI   = 3;
   localparam int          TD   = 4;
   localparam int          GC   = 2;
   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          SHOW_LEN = (CI + 1) * TD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       finish = 1'b0;
   logic [1:0] c1, c2;
   logic [2:0] n1, n2;
   logic [7:0] count;
   logic       round_active;
   logic [3:0] round_idx;
   logic       timeout;
   logic       game_over;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] ref_l;
   int exp_c1, exp_n1, exp_c2, exp_n2;

   card_round_ctrl #(
      .NUM_ROUNDS (NR),
      .COUNT_INIT (8'(CI)),
      .TICK_DIV   (TD),
      .GAP_CYCLES (GC),
      .SEED       (SEED)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .finish       (finish),
      .c1           (c1),
      .c2           (c2),
      .n1           (n1),
      .n2           (n2),
      .count        (count),
      .round_active (round_active),
      .round_idx    (round_idx),
      .timeout      (timeout),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int card_num(input int r);
      return (r < 5) ? r + 1 : r - 4;
   endfunction

   // Reference: advance the spec LFSR one step and derive the expected cards
   task automatic model_deal();
      ref_l  = {ref_l[14:0], ref_l[15] ^ ref_l[13] ^ ref_l[12] ^ ref_l[10]};
      exp_c1 = int'(ref_l[1:0]);
      exp_n1 = card_num(int'(ref_l[4:2]));
      exp_c2 = int'(ref_l[6:5]);
      exp_n2 = card_num(int'(ref_l[9:7]));
   endtask

   function automatic int exp_count(input int k);
      return CI - (k - 1) / TD;
   endfunction

   task automatic chk_zero(input string pfx);
      chk({pfx, "_c1"}, 32'(c1), 0);
      chk({pfx, "_n1"}, 32'(n1), 0);
      chk({pfx, "_c2"}, 32'(c2), 0);
      chk({pfx, "_n2"}, 32'(n2), 0);
      chk({pfx, "_count"}, 32'(count), 0);
      chk({pfx, "_active"}, 32'(round_active), 0);
      chk({pfx, "_ridx"}, 32'(round_idx), 0);
      chk({pfx, "_timeout"}, 32'(timeout), 0);
      chk({pfx, "_game_over"}, 32'(game_over), 0);
   endtask

   task automatic chk_cards(input string pfx);
      chk({pfx, "_c1"}, 32'(c1), 32'(exp_c1));
      chk({pfx, "_n1"}, 32'(n1), 32'(exp_n1));
      chk({pfx, "_c2"}, 32'(c2), 32'(exp_c2));
      chk({pfx, "_n2"}, 32'(n2), 32'(exp_n2));
   endtask

   // Called on the negedge where DEAL is visible; ends on SHOW cycle 1
   task automatic deal_check(input int ridx);
      chk("deal_ridx", 32'(round_idx), 32'(ridx));
      chk("deal_active", 32'(round_active), 0);
      chk("deal_game_over", 32'(game_over), 0);
      @(negedge clk);
      model_deal();
      chk_cards("show1");
      chk("show1_count", 32'(count), 32'(CI));
      chk("show1_active", 32'(round_active), 1);
      chk("show1_ridx", 32'(round_idx), 32'(ridx));
   endtask

   // Runs one round from SHOW cycle 1; ends on the DEAL or DONE negedge
   task automatic play_round(input int ridx, input int push_at);
      int final_cnt;
      final_cnt = 0;
      for (int k = 1; k <= SHOW_LEN; k++) begin
         chk("show_count", 32'(count), 32'(exp_count(k)));
         chk("show_active", 32'(round_active), 1);
         chk("show_timeout", 32'(timeout), 0);
         finish = (k == push_at);
         start  = 1'($urandom_range(0, 1));
         @(negedge clk);
         finish = 1'b0;
         start  = 1'b0;
         if (k == push_at) begin
            final_cnt = exp_count(k);
            chk("push_active", 32'(round_active), 0);
            chk("push_timeout", 32'(timeout), 0);
            chk("push_count", 32'(count), 32'(final_cnt));
            break;
         end
         if (k == SHOW_LEN) begin
            final_cnt = 0;
            chk("to_timeout", 32'(timeout), 1);
            chk("to_active", 32'(round_active), 0);
            chk("to_count", 32'(count), 0);
         end
      end
      for (int g = 1; g < GC; g++) begin
         finish = 1'($urandom_range(0, 1));
         @(negedge clk);
         finish = 1'b0;
         chk("gap_timeout", 32'(timeout), 0);
         chk("gap_active", 32'(round_active), 0);
         chk("gap_count", 32'(count), 32'(final_cnt));
         chk_cards("gap");
      end
      @(negedge clk);
      if (ridx == NR - 1) begin
         chk("done_game_over", 32'(game_over), 1);
         chk("done_active", 32'(round_active), 0);
         chk("done_ridx", 32'(round_idx), 32'(ridx));
      end
   endtask

   task automatic start_game();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic play_game(input int p0, input int p1);
      start_game();
      deal_check(0);
      play_round(0, p0);
      deal_check(1);
      play_round(1, p1);
   endtask

   initial begin
      ref_l = SEED;

      // Reset state
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_zero("rst");
      @(negedge clk);
      chk_zero("idle");

      // Game 1: first deal against known values, timeout round, early push round
      start_game();
      deal_check(0);
      chk("first_c1", 32'(c1), 3);
      chk("first_n1", 32'(n1), 1);
      chk("first_c2", 32'(c2), 2);
      chk("first_n2", 32'(n2), 4);
      play_round(0, 0);
      deal_check(1);
      play_round(1, 6);

      // Idle in DONE for a while, start must restart from round 0
      repeat (3) @(negedge clk);
      chk("done_hold", 32'(game_over), 1);

      // Game 2: simultaneous push and expiry, then a random push
      play_game(SHOW_LEN, int'($urandom_range(0, SHOW_LEN)));

      // Game 3: reset in the middle of SHOW
      start_game();
      deal_check(0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      ref_l = SEED;
      chk_zero("midrst");
      @(negedge clk);
      chk_zero("midrst_idle");

      // Game 4: reseeded deal reproduces the first cards
      start_game();
      deal_check(0);
      chk("reseed_c1", 32'(c1), 3);
      chk("reseed_n1", 32'(n1), 1);
      chk("reseed_c2", 32'(c2), 2);
      chk("reseed_n2", 32'(n2), 4);
      play_round(0, int'($urandom_range(0, SHOW_LEN)));
      deal_check(1);
      play_round(1, int'($urandom_range(0, SHOW_LEN)));

      // A few more randomized games
      for (int g = 0; g < 4; g++) begin
         play_game(int'($urandom_range(0, SHOW_LEN)), int'($urandom_range(0, SHOW_LEN)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
